// File: rtl/vector_arbiter_pkg.sv
// vector_arbiter_pkg: shared FSM/op encodings and default widths for the vector arbiter
package vector_arbiter_pkg;
   localparam int DEF_DATA_WIDTH  = 20;
   localparam int DEF_INDEX_WIDTH = 8;
   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ISSUE     = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;
   typedef enum logic [1:0] {OP_NONE = 2'd0, OP_GET = 2'd1, OP_INSERT = 2'd2} op_t;
endpackage

// File: rtl/vector_req_slot.sv
// vector_req_slot: one pending-command slot; empty when op is OP_NONE
module vector_req_slot
   import vector_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   get,
   input  logic                   insert,
   input  logic [INDEX_WIDTH-1:0] index,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   clear,
   output logic                   ready,
   output op_t                    op,
   output logic [INDEX_WIDTH-1:0] slot_index,
   output logic [DATA_WIDTH-1:0]  slot_data,
   output logic                   violation
);
   logic cmd;
   always_comb begin
      cmd       = get | insert;
      ready     = (op == OP_NONE);
      violation = cmd & (~ready | (get & insert));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op         <= OP_NONE;
         slot_index <= '0;
         slot_data  <= '0;
      end else if (clear) begin
         op <= OP_NONE;
      end else if (cmd && ready) begin
         op         <= insert ? OP_INSERT : OP_GET;
         slot_index <= index;
         slot_data  <= data_in;
      end
   end
endmodule

// File: rtl/vector_arbiter.sv
// vector_arbiter: round-robin arbitration of two requesters onto one shared vector
module vector_arbiter
   import vector_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [INDEX_WIDTH-1:0] req0_index,
   input  logic                   req0_get,
   input  logic                   req0_insert,
   input  logic [DATA_WIDTH-1:0]  req0_data_in,
   output logic                   req0_ready,
   output logic [DATA_WIDTH-1:0]  req0_data_out,
   input  logic [INDEX_WIDTH-1:0] req1_index,
   input  logic                   req1_get,
   input  logic                   req1_insert,
   input  logic [DATA_WIDTH-1:0]  req1_data_in,
   output logic                   req1_ready,
   output logic [DATA_WIDTH-1:0]  req1_data_out,
   output logic [INDEX_WIDTH-1:0] vec_index,
   output logic                   vec_get,
   output logic                   vec_insert,
   output logic [DATA_WIDTH-1:0]  vec_data_in,
   input  logic [DATA_WIDTH-1:0]  vec_data_out,
   input  logic                   vec_ready,
   output logic                   err
);
   op_t                   op0, op1, g_op;
   logic [INDEX_WIDTH-1:0] idx0, idx1;
   logic [DATA_WIDTH-1:0]  d0, d1;
   logic                   v0, v1, clr0, clr1, p0, p1, sel, complete;
   logic [1:0]             state;
   logic                   grant, rr, busy_cnt;
   vector_req_slot #(.DATA_WIDTH(DATA_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) u_slot0 (
      .clk(clk), .rst_n(rst_n), .get(req0_get), .insert(req0_insert), .index(req0_index),
      .data_in(req0_data_in), .clear(clr0), .ready(req0_ready), .op(op0),
      .slot_index(idx0), .slot_data(d0), .violation(v0)
   );
   vector_req_slot #(.DATA_WIDTH(DATA_WIDTH), .INDEX_WIDTH(INDEX_WIDTH)) u_slot1 (
      .clk(clk), .rst_n(rst_n), .get(req1_get), .insert(req1_insert), .index(req1_index),
      .data_in(req1_data_in), .clear(clr1), .ready(req1_ready), .op(op1),
      .slot_index(idx1), .slot_data(d1), .violation(v1)
   );
   // rr names the preferred requester when both slots are pending
   always_comb begin
      p0          = (op0 != OP_NONE);
      p1          = (op1 != OP_NONE);
      sel         = (p0 && p1) ? rr : p1;
      g_op        = grant ? op1 : op0;
      vec_index   = grant ? idx1 : idx0;
      vec_data_in = grant ? d1 : d0;
      vec_get     = (state == S_ISSUE) && (g_op == OP_GET);
      vec_insert  = (state == S_ISSUE) && (g_op == OP_INSERT);
      complete    = vec_ready && (state == S_WAIT_DONE || (state == S_WAIT_BUSY && busy_cnt));
      clr0        = complete && !grant;
      clr1        = complete && grant;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         grant         <= 1'b0;
         rr            <= 1'b0;
         busy_cnt      <= 1'b0;
         err           <= 1'b0;
         req0_data_out <= '0;
         req1_data_out <= '0;
      end else begin
         err <= err | v0 | v1;
         case (state)
            S_IDLE: if ((p0 || p1) && vec_ready) begin
               grant <= sel;
               state <= S_ISSUE;
            end
            S_ISSUE: begin
               busy_cnt <= 1'b0;
               state    <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               busy_cnt <= 1'b1;
               if (!vec_ready) state <= S_WAIT_DONE;
            end
            default: ;
         endcase
         if (complete) begin
            state <= S_IDLE;
            rr    <= ~grant;
            if (g_op == OP_GET && !grant) req0_data_out <= vec_data_out;
            if (g_op == OP_GET && grant) req1_data_out <= vec_data_out;
         end
      end
   end
endmodule

// File: tb/tb_vector_arbiter.sv
// tb_vector_arbiter: scoreboard bench with a behavioural vector model
module tb_vector_arbiter;
   typedef struct packed {
      logic        g;
      logic        i;
      logic [7:0]  idx;
      logic [19:0] d;
   } op_rec_t;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [7:0]  req0_index = '0, req1_index = '0, vec_index;
   logic        req0_get = 0, req0_insert = 0, req1_get = 0, req1_insert = 0;
   logic [19:0] req0_data_in = '0, req1_data_in = '0, req0_data_out, req1_data_out, vec_data_in;
   logic        req0_ready, req1_ready, vec_get, vec_insert, vec_ready, err;
   logic [19:0] vec_data_out = '0;
   logic [19:0] mem [256] = '{default: '0};
   int          busy = 0, lat = 1, errors = 0, checks = 0;
   op_rec_t     exp_q[$], obs_q[$];
   vector_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_index(req0_index), .req0_get(req0_get), .req0_insert(req0_insert),
      .req0_data_in(req0_data_in), .req0_ready(req0_ready), .req0_data_out(req0_data_out),
      .req1_index(req1_index), .req1_get(req1_get), .req1_insert(req1_insert),
      .req1_data_in(req1_data_in), .req1_ready(req1_ready), .req1_data_out(req1_data_out),
      .vec_index(vec_index), .vec_get(vec_get), .vec_insert(vec_insert),
      .vec_data_in(vec_data_in), .vec_data_out(vec_data_out), .vec_ready(vec_ready), .err(err)
   );
   always #5 clk = ~clk;
   assign vec_ready = (busy == 0);
   // vector model drops ready for lat cycles after each op and records every op cycle
   always @(posedge clk) begin
      if (busy > 0) busy <= busy - 1;
      if (vec_get || vec_insert) begin
         obs_q.push_back('{g: vec_get, i: vec_insert, idx: vec_index, d: vec_data_in});
         busy <= lat;
         if (vec_insert) mem[vec_index] <= vec_data_in;
         vec_data_out <= mem[vec_index];
      end
   end
   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic test_reset();
      do_reset();
      checks += 6;
      if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0 got=%b want=1", req0_ready); end
      if (req1_ready !== 1'b1) begin errors++; $display("FAIL reset_ready1 got=%b want=1", req1_ready); end
      if (vec_get !== 1'b0) begin errors++; $display("FAIL reset_vec_get got=%b want=0", vec_get); end
      if (vec_insert !== 1'b0) begin errors++; $display("FAIL reset_vec_insert got=%b want=0", vec_insert); end
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
      if (req0_data_out !== 20'h0) begin errors++; $display("FAIL reset_data0 got=%h want=0", req0_data_out); end
   endtask
   task automatic test_single_insert();
      int cyc;
      op_rec_t e, o;
      @(negedge clk);
      req0_insert = 1; req0_index = 8'd5; req0_data_in = 20'h00A00;
      exp_q.push_back('{g: 1'b0, i: 1'b1, idx: 8'd5, d: 20'h00A00});
      @(negedge clk);
      req0_insert = 0;
      checks++;
      if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_busy got=%b want=0", req0_ready); end
      cyc = 0;
      while (!req0_ready && cyc < 50) begin @(negedge clk); cyc++; end
      checks++;
      if (cyc != 4) begin errors++; $display("FAIL single_latency got=%0d want=4", cyc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL single_op got=none want=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o.g !== e.g || o.i !== e.i || o.idx !== e.idx || (e.i && o.d !== e.d)) begin
               errors++; $display("FAIL single_op got=%h want=%h", o, e);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL single_extra got=%0d want=0", obs_q.size()); end
   endtask
   task automatic test_no_drop();
      int cyc;
      lat = 0;
      @(negedge clk);
      req0_get = 1; req0_index = 8'd5;
      @(negedge clk);
      req0_get = 0;
      cyc = 0;
      while (!req0_ready && cyc < 50) begin @(negedge clk); cyc++; end
      checks += 3;
      if (cyc >= 50) begin errors++; $display("FAIL nodrop_timeout got=%0d want<50", cyc); end
      if (req0_data_out !== 20'h00A00) begin errors++; $display("FAIL nodrop_data got=%h want=00a00", req0_data_out); end
      if (obs_q.size() != 1) begin errors++; $display("FAIL nodrop_ops got=%0d want=1", obs_q.size()); end
      obs_q.delete();
      lat = 1;
   endtask
   task automatic test_contention();
      int cyc;
      op_rec_t e, o;
      do_reset();
      req0_insert = 1; req0_index = 8'd1; req0_data_in = 20'h00A00;
      req1_get = 1; req1_index = 8'd1; req1_data_in = 20'h0;
      exp_q.push_back('{g: 1'b0, i: 1'b1, idx: 8'd1, d: 20'h00A00});
      exp_q.push_back('{g: 1'b1, i: 1'b0, idx: 8'd1, d: 20'h0});
      @(negedge clk);
      req0_insert = 0; req1_get = 0;
      cyc = 0;
      while (!(req0_ready && req1_ready) && cyc < 100) begin @(negedge clk); cyc++; end
      checks += 2;
      if (req1_data_out !== 20'h00A00) begin errors++; $display("FAIL contention_data1 got=%h want=00a00", req1_data_out); end
      if (req0_data_out !== 20'h0) begin errors++; $display("FAIL contention_data0 got=%h want=0", req0_data_out); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL contention_op got=none want=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o.g !== e.g || o.i !== e.i || o.idx !== e.idx || (e.i && o.d !== e.d)) begin
               errors++; $display("FAIL contention_op got=%h want=%h", o, e);
            end
         end
      end
   endtask
   task automatic test_fairness();
      int cyc, n0, n1;
      op_rec_t e, o;
      n0 = 0; n1 = 0; cyc = 0;
      while ((n0 < 4 || n1 < 4 || !req0_ready || !req1_ready) && cyc < 400) begin
         @(negedge clk);
         cyc++;
         req0_insert = 0; req1_get = 0;
         if (req0_ready && n0 < 4) begin
            req0_insert = 1; req0_index = 8'(16 + n0); req0_data_in = 20'(32'h100 + n0);
            exp_q.push_back('{g: 1'b0, i: 1'b1, idx: 8'(16 + n0), d: 20'(32'h100 + n0)});
            n0++;
         end
         if (req1_ready && n1 < 4) begin
            req1_get = 1; req1_index = 8'(32 + n1);
            exp_q.push_back('{g: 1'b1, i: 1'b0, idx: 8'(32 + n1), d: 20'h0});
            n1++;
         end
      end
      @(negedge clk);
      req0_insert = 0; req1_get = 0;
      cyc = 0;
      while (!(req0_ready && req1_ready) && cyc < 100) begin @(negedge clk); cyc++; end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL fair_op got=none want=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o.g !== e.g || o.i !== e.i || o.idx !== e.idx || (e.i && o.d !== e.d)) begin
               errors++; $display("FAIL fair_op got=%h want=%h", o, e);
            end
         end
      end
   endtask
   task automatic test_violations();
      int cyc;
      op_rec_t e, o;
      do_reset();
      req1_insert = 1; req1_index = 8'd9; req1_data_in = 20'h00055;
      exp_q.push_back('{g: 1'b0, i: 1'b1, idx: 8'd9, d: 20'h00055});
      @(negedge clk);
      req1_insert = 0; req1_get = 1;
      @(negedge clk);
      req1_get = 0;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL viol_busy_err got=%b want=1", err); end
      cyc = 0;
      while (!(req0_ready && req1_ready) && cyc < 100) begin @(negedge clk); cyc++; end
      req0_get = 1; req0_insert = 1; req0_index = 8'd7; req0_data_in = 20'h00123;
      exp_q.push_back('{g: 1'b0, i: 1'b1, idx: 8'd7, d: 20'h00123});
      @(negedge clk);
      req0_get = 0; req0_insert = 0;
      cyc = 0;
      while (!(req0_ready && req1_ready) && cyc < 100) begin @(negedge clk); cyc++; end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL viol_op got=none want=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o.g !== e.g || o.i !== e.i || o.idx !== e.idx || (e.i && o.d !== e.d)) begin
               errors++; $display("FAIL viol_op got=%h want=%h", o, e);
            end
         end
      end
      checks += 3;
      if (obs_q.size() != 0) begin errors++; $display("FAIL viol_extra got=%0d want=0", obs_q.size()); end
      if (err !== 1'b1) begin errors++; $display("FAIL viol_sticky got=%b want=1", err); end
      if (req0_data_out !== 20'h0) begin errors++; $display("FAIL viol_data0 got=%h want=0", req0_data_out); end
   endtask
   task automatic test_reset_mid_op();
      int cyc;
      op_rec_t e, o;
      lat = 6;
      req0_get = 1; req0_index = 8'd3;
      @(negedge clk);
      req0_get = 0;
      cyc = 0;
      while (!(obs_q.size() == 1 && !vec_ready) && cyc < 50) begin @(negedge clk); cyc++; end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      obs_q.delete();
      checks += 4;
      if (req0_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready0 got=%b want=1", req0_ready); end
      if (req1_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready1 got=%b want=1", req1_ready); end
      if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got=%b want=0", err); end
      if (req0_data_out !== 20'h0) begin errors++; $display("FAIL midrst_data0 got=%h want=0", req0_data_out); end
      repeat (12) @(negedge clk);
      checks++;
      if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_stray got=%0d want=0", obs_q.size()); end
      lat = 1;
      req1_insert = 1; req1_index = 8'd40; req1_data_in = 20'hBEEF0;
      exp_q.push_back('{g: 1'b0, i: 1'b1, idx: 8'd40, d: 20'hBEEF0});
      @(negedge clk);
      req1_insert = 0;
      cyc = 0;
      while (!req1_ready && cyc < 50) begin @(negedge clk); cyc++; end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin errors++; $display("FAIL midrst_op got=none want=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o.g !== e.g || o.i !== e.i || o.idx !== e.idx || (e.i && o.d !== e.d)) begin
               errors++; $display("FAIL midrst_op got=%h want=%h", o, e);
            end
         end
      end
   endtask
   initial begin
      test_reset();
      test_single_insert();
      test_no_drop();
      test_contention();
      test_fairness();
      test_violations();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vector_arbiter.md
VECTOR_ARBITER -- requirements
Module: vector_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 20, width of one vector element (fixed-point value plus tag bit).
REQ-002 Parameter INDEX_WIDTH, default 8, width of the vector index ($clog2(64)+2).
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Ports reqN_index (input, INDEX_WIDTH), reqN_get (input, 1), reqN_insert (input, 1), reqN_data_in (input, DATA_WIDTH) for N = 0 (parser side) and N = 1 (stack-machine side): one-cycle command pulse plus operands.
REQ-006 Ports reqN_ready (output, 1) and reqN_data_out (output, DATA_WIDTH) for N = 0, 1: requester idle and last read result.
REQ-007 Ports vec_index (output, INDEX_WIDTH), vec_get (output, 1), vec_insert (output, 1), vec_data_in (output, DATA_WIDTH) drive the single shared vector.
REQ-008 Ports vec_data_out (input, DATA_WIDTH) and vec_ready (input, 1) come from the vector.
REQ-009 Port err  output  1  sticky protocol-violation flag.

Function
REQ-010 The block SHALL hold one pending slot per requester; a slot latches index, data and op on a cycle where reqN_get or reqN_insert is high while reqN_ready is high.
REQ-011 reqN_ready SHALL be high exactly when slot N is empty, and go low the cycle after the accepting edge.
REQ-012 When reqN_get and reqN_insert are both high on an accepting cycle, the block SHALL latch an insert, drop the get, and set err.
REQ-013 A command pulse while reqN_ready is low SHALL be ignored and SHALL set err.
REQ-014 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: if any slot is pending and vec_ready is high, select a slot and go to ISSUE; else stay.
REQ-016 Selection SHALL be round-robin: with both pending, grant the slot not granted last; with one pending, grant it.
REQ-017 ISSUE: drive vec_index, vec_data_in and exactly one of vec_get/vec_insert high for one cycle from the granted slot, then go to WAIT_BUSY.
REQ-018 WAIT_BUSY: on vec_ready low go to WAIT_DONE; if vec_ready stays high for 2 cycles, treat the op as complete and go to the completion action.
REQ-019 WAIT_DONE: on vec_ready high, perform completion: for get, copy vec_data_out into reqN_data_out; clear slot N; flip the round-robin pointer; go to IDLE.
REQ-020 reqN_data_out SHALL hold its value until the next completed get of that requester; inserts SHALL not modify it.
REQ-021 vec_get and vec_insert SHALL be low in every state except ISSUE; vec_index and vec_data_in SHALL hold the granted operands from ISSUE through completion.
REQ-022 A requester whose slot clears on cycle t SHALL be able to issue a new command on cycle t+1; minimum accept-to-ready latency is 4 cycles with a 1-cycle vector.
REQ-023 Simultaneous accept on both requesters in one cycle SHALL latch both slots; no command is lost.

Reset
REQ-024 rst_n low on a rising edge SHALL force IDLE, clear both slots, round-robin pointer to requester 0, err to 0, reqN_data_out to 0, vec_get/vec_insert to 0, regardless of any in-flight vector op.
REQ-025 After rst_n returns high, reqN_ready SHALL be high on the first cycle.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the op encoding (NONE/GET/INSERT) and default DATA_WIDTH/INDEX_WIDTH constants.
REQ-027 The pending slot SHALL be one sub-module, vector_req_slot, instantiated twice.

Verification
REQ-028 Reset: rst_n low 2 cycles -> req0_ready=req1_ready=1, vec_get=vec_insert=0, err=0.
REQ-029 Single insert: req0 insert index 5 data 0x00A00 -> one-cycle vec_insert with vec_index=5, vec_data_in=0x00A00; req0_ready returns high after vec_ready rises.
REQ-030 Contention: req0 insert idx 1 and req1 get idx 1 same cycle -> insert issued first (pointer at 0), then get; req1_data_out=0x00A00.
REQ-031 Fairness: both requesters re-issue immediately for 4 rounds -> grants alternate 0,1,0,1,...; no requester granted twice in a row while the other pends.
REQ-032 Violations: req1 pulses get while req1_ready=0, and req0 pulses get+insert together -> err=1 and stays 1; only one insert from req0 reaches vector.
REQ-033 Reset mid-op: rst_n low during WAIT_DONE -> IDLE next cycle, both slots empty, no further vec_get/vec_insert until a new request.
